// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async_fifo block.
//   DEFAULT_WIDTH     - default data word width in bits
//   DEFAULT_FIFO_SIZE - default depth in words (power of two, >= 2)
//   ptr_width()       - index width for a given depth
package async_fifo_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_FIFO_SIZE = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// fifo_mem: simple dual-port register array for the FIFO storage.
//   clk     - clock, all activity on rising edge
//   rst_n   - synchronous active-low reset; clears only the read register
//   wr_en   - write strobe (already qualified by the caller)
//   wr_addr - write index
//   wdata   - write data
//   rd_en   - read strobe (already qualified by the caller)
//   rd_addr - read index
//   rdata   - registered read data, holds when rd_en is low
module fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE,
  parameter int AW        = ptr_width(FIFO_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [FIFO_SIZE];

  // Storage is never cleared; a reset only invalidates it through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock synchronous FIFO with full/empty status and
// one-cycle overflow/underflow pulses. Illegal accesses are dropped.
//   clk       - single clock
//   rst_n     - synchronous active-low reset
//   wr_en     - write request, wdata sampled with it
//   wdata     - write data
//   rd_en     - read request
//   rdata     - registered read data, holds when no read is accepted
//   full      - FIFO holds FIFO_SIZE words
//   empty     - FIFO holds no words
//   overflow  - high the cycle after a write attempted while full
//   underflow - high the cycle after a read attempted while empty
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_WIDTH = ptr_width(FIFO_SIZE);

  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic               wr_acc;
  logic               rd_acc;

  // The extra MSB distinguishes a full wrap from an empty FIFO when the
  // index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                 (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

  // Both requests are judged against the flags at the start of the cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_mem #(
    .WIDTH     (WIDTH),
    .FIFO_SIZE (FIFO_SIZE),
    .AW        (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata   (wdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed testbench for async_fifo (WIDTH=8, FIFO_SIZE=16).
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  async_fifo #(.WIDTH(8), .FIFO_SIZE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_one(input logic [7:0] v);
    wr_en = 1'b1; rd_en = 1'b0; wdata = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_one();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_one(8'(50 + i));
      if (i == 0) begin
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_first_empty got=%b exp=0", empty); end
      end
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_empty();
    // Continues from the full FIFO left by test_full.
    for (int i = 0; i < 16; i++) begin
      read_one();
      checks++; if (rdata !== 8'(50 + i)) begin errors++; $display("FAIL empty_rdata[%0d] got=%0d exp=%0d", i, rdata, 50 + i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_flag got=%b exp=1", empty); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL empty_udf got=%b exp=0", underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) write_one(8'(50 + i));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      read_one();
      if (i == 0) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_width got=%b exp=0", overflow); end
      end
      checks++; if (rdata !== 8'(50 + i)) begin errors++; $display("FAIL ovf_rdata[%0d] got=%0d exp=%0d", i, rdata, 50 + i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 16; i++) write_one(8'(50 + i));
    for (int i = 0; i < 17; i++) begin
      read_one();
      if (i == 15) begin
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_early got=%b exp=0", underflow); end
      end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b exp=1", underflow); end
    checks++; if (rdata !== 8'd65) begin errors++; $display("FAIL udf_hold got=%0d exp=65", rdata); end
    step();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_width got=%b exp=0", underflow); end
  endtask

  task automatic test_back_to_back_errors();
    do_reset();
    // Simultaneous read and write while empty: write wins, read flagged.
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hA5;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simul_empty_udf got=%b exp=1", underflow); end
    checks++; if (empty !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL simul_empty_state got=empty%b/%h exp=empty0/00", empty, rdata); end
    for (int i = 1; i < 16; i++) write_one(8'(8'h10 + i));
    // Two rejected writes in a row keep overflow high.
    wr_en = 1'b1; wdata = 8'hEE;
    step();
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf got=%b exp=1", overflow); end
    // Simultaneous while full: read wins, write flagged.
    rd_en = 1'b1; wdata = 8'hDD;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (rdata !== 8'hA5 || overflow !== 1'b1) begin errors++; $display("FAIL simul_full got=%h/ovf%b exp=a5/ovf1", rdata, overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full_flag got=%b exp=0", full); end
    read_one();
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL simul_full_next got=%h exp=11", rdata); end
  endtask

  task automatic test_concurrent_wrap();
    logic [7:0] v;
    int bad;
    do_reset();
    bad = 0;
    write_one(8'd100);
    for (int i = 1; i < 20; i++) begin
      v = 8'(100 + 3 * i);
      wr_en = 1'b1; rd_en = 1'b1; wdata = v;
      step();
      checks++;
      if (rdata !== 8'(100 + 3 * (i - 1)) || overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL wrap[%0d] got=%0d ovf=%b udf=%b exp=%0d ovf=0 udf=0", i, rdata, overflow, underflow, 100 + 3 * (i - 1));
      end
    end
    wr_en = 1'b0;
    read_one();
    checks++; if (rdata !== 8'(100 + 3 * 19)) begin errors++; $display("FAIL wrap_last got=%0d exp=%0d", rdata, 100 + 57); end
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL wrap_end got=empty%b/udf%b exp=empty1/udf0", empty, underflow); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 8; i++) write_one(8'(200 + i));
    read_one();
    checks++; if (rdata !== 8'd200) begin errors++; $display("FAIL midop_pre got=%0d exp=200", rdata); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL midop_flags got=empty%b/full%b exp=empty1/full0", empty, full); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midop_rdata got=%h exp=00", rdata); end
    read_one();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL midop_udf got=%b exp=1", underflow); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_empty();
    test_overflow();
    test_underflow();
    test_back_to_back_errors();
    test_concurrent_wrap();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
